// File: rtl/tqvp_fixmath_engine.sv
// Unsigned fixed-point coprocessor for the TinyQV bus: sqrt, sqrtrem, square, multiply,
// multiply-accumulate and hypot on one iterative shift-add multiplier and one digit-by-digit root unit.
module tqvp_fixmath_engine #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 16,
  parameter int SATURATE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  localparam int N  = WIDTH + FBITS;
  localparam int RW = N / 2;
  localparam int RB = RW + 2;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_MUL2, S_ADD, S_SQRT, S_WB} state_t;
  state_t fsm_state, state_n;

  logic [3:0]         op;
  logic               ie, done, ovf, err;
  logic [7:0]         cyc, cyc_run;
  logic [WIDTH-1:0]   a, b, c, val, tmp, mcand;
  logic [2*WIDTH-1:0] prod;
  logic [N-1:0]       sq_rad;
  logic [RB-1:0]      sq_rem;
  logic [RW-1:0]      sq_root;
  logic [CW-1:0]      cnt;

  logic        we, wr_ctrl, wr_a, wr_b, wr_c, wr_irqclr;
  logic [31:0] wmask;
  logic [3:0]  op_new;
  logic        op_legal, start_ok, busy, wb, mul_step, mul_last, sq_last, sq_load;

  function automatic logic sqrt_only(input logic [3:0] o);
    return (o == 4'd0) || (o == 4'd1) || (o == 4'd4) || (o == 4'd5);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always_comb begin
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  assign we        = (data_write_n != 2'b11);
  assign wr_ctrl   = we && (address == 6'h00);
  assign wr_a      = we && (address == 6'h04);
  assign wr_b      = we && (address == 6'h08);
  assign wr_c      = we && (address == 6'h0C);
  assign wr_irqclr = we && (address == 6'h10);
  assign op_new    = data_in[3:0];
  assign op_legal  = (op_new <= 4'd8);
  assign start_ok  = wr_ctrl && data_in[4] && !busy && op_legal;
  assign mul_last  = (cnt == CW'(WIDTH - 1));
  assign sq_last   = (cnt == CW'(RW - 1));

  // Multiplier step: product register holds {partial sum, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {mul_sum, prod[WIDTH-1:1]};
  assign mul_ovf   = |prod_next[2*WIDTH-1:N];
  assign mul_res   = (mul_ovf && SATURATE != 0) ? '1 : prod_next[N-1:FBITS];

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_res;
  assign add_sum = {1'b0, (op == 4'd6) ? tmp : c} + {1'b0, val};
  assign add_res = (add_sum[WIDTH] && SATURATE != 0) ? '1 : add_sum[WIDTH-1:0];

  logic [RB-1:0]    rem_sh, trial, rem_n;
  logic [RW-1:0]    root_n;
  logic             ge;
  logic [WIDTH-1:0] sq_src;
  assign rem_sh = {sq_rem[RB-3:0], sq_rad[N-1:N-2]};
  assign trial  = {sq_root, 2'b01};
  assign ge     = (rem_sh >= trial);
  assign rem_n  = ge ? rem_sh - trial : rem_sh;
  assign root_n = {sq_root[RW-2:0], ge};
  assign sq_src = (fsm_state == S_ADD) ? add_res :
                  ((op_new == 4'd4) || (op_new == 4'd5)) ? c : a;

  always_ff @(posedge clk) begin
    if (rst) fsm_state <= S_IDLE;
    else     fsm_state <= state_n;
  end

  always_comb begin
    state_n = fsm_state;
    case (fsm_state)
      S_IDLE: if (start_ok) state_n = sqrt_only(op_new) ? S_SQRT : S_MUL;
      S_MUL:  if (mul_last) state_n = (op == 4'd6) ? S_MUL2 :
                                      ((op == 4'd3) || (op == 4'd8)) ? S_ADD : S_WB;
      S_MUL2: if (mul_last) state_n = S_ADD;
      S_ADD:  state_n = (op == 4'd6) ? S_SQRT : S_WB;
      S_SQRT: if (sq_last) state_n = S_WB;
      S_WB:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (fsm_state != S_IDLE);
    wb       = (fsm_state == S_WB);
    mul_step = (fsm_state == S_MUL) || (fsm_state == S_MUL2);
    sq_load  = (start_ok && sqrt_only(op_new)) || ((fsm_state == S_ADD) && (op == 4'd6));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0; prod <= '0; val <= '0; tmp <= '0;
      sq_rad <= '0; sq_rem <= '0; sq_root <= '0; cnt <= '0; cyc_run <= '0;
    end else begin
      cnt <= ((state_n != fsm_state) || !busy) ? '0 : cnt + 1'b1;
      if (busy) cyc_run <= (cyc_run == 8'hFF) ? 8'hFF : cyc_run + 8'd1;
      if (start_ok) begin
        cyc_run <= '0;
        mcand   <= a;
        prod    <= {{WIDTH{1'b0}}, ((op_new == 4'd7) || (op_new == 4'd8)) ? b : a};
      end
      if (mul_step) prod <= prod_next;
      // Reload for the second square; only op 6 goes on to use it.
      if (fsm_state == S_MUL && mul_last) begin
        val   <= mul_res;
        mcand <= b;
        prod  <= {{WIDTH{1'b0}}, b};
      end
      if (fsm_state == S_MUL2 && mul_last) tmp <= mul_res;
      if (fsm_state == S_ADD) val <= add_res;
      if (sq_load) begin
        sq_rad  <= N'(sq_src) << FBITS;
        sq_rem  <= '0;
        sq_root <= '0;
      end else if (fsm_state == S_SQRT) begin
        sq_rad  <= sq_rad << 2;
        sq_rem  <= rem_n;
        sq_root <= root_n;
        if (sq_last) val <= ((op == 4'd1) || (op == 4'd5)) ? WIDTH'(rem_n) : WIDTH'(root_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0; ie <= 1'b0; done <= 1'b0; ovf <= 1'b0; err <= 1'b0; cyc <= '0;
      a <= '0; b <= '0; c <= '0;
    end else begin
      if (wr_ctrl) begin
        ie <= data_in[5];
        if (!busy) op <= op_new;
        else if (data_in[4] || (op_new != op)) err <= 1'b1;
        if (!busy && data_in[4] && !op_legal) err <= 1'b1;
      end
      if (busy && (wr_a || wr_b || wr_c)) err <= 1'b1;
      if (!busy && wr_a) a <= WIDTH'(merge(32'(a), data_in, wmask));
      if (!busy && wr_b) b <= WIDTH'(merge(32'(b), data_in, wmask));
      if (!busy && wr_c) c <= WIDTH'(merge(32'(c), data_in, wmask));
      if (start_ok) begin
        done <= 1'b0; ovf <= 1'b0; err <= 1'b0;
      end
      if (mul_step && mul_last && mul_ovf) ovf <= 1'b1;
      if (fsm_state == S_ADD && add_sum[WIDTH]) ovf <= 1'b1;
      if (wr_irqclr && data_in[0]) done <= 1'b0;
      // A completion on the same edge as an IRQCLR write keeps DONE set.
      if (wb) begin
        c    <= val;
        done <= 1'b1;
        cyc  <= (cyc_run == 8'hFF) ? 8'hFF : cyc_run + 8'd1;
      end
    end
  end

  always_comb begin
    case (address)
      6'h00:   data_out = {8'b0, cyc, 4'b0, err, ovf, done, busy, 2'b0, ie, 1'b0, op};
      6'h04:   data_out = 32'(a);
      6'h08:   data_out = 32'(b);
      6'h0C:   data_out = 32'(c);
      default: data_out = 32'h0;
    endcase
  end

  assign uo_out         = {5'b0, done, busy, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = done & ie;

  logic unused;
  assign unused = ^{ui_in, data_read_n, prod_next[FBITS-1:0]};
endmodule
